// File: rtl/but_debounce_pkg.sv
// Shared FSM encodings and default timing constants for the button conditioner,
// so the top-level design and its bench agree on them.
package but_debounce_pkg;

  typedef enum logic [1:0] {
    StReleased    = 2'd0,
    StPressWait   = 2'd1,
    StPressed     = 2'd2,
    StReleaseWait = 2'd3
  } but_state_e;

  localparam int unsigned DefDebounceCycles = 16;
  localparam int unsigned DefLongCycles     = 1024;

endpackage

// File: rtl/but_sync.sv
// Two-flop synchroniser for an asynchronous pin; both flops reset to RESET_VAL
// so the idle pin level is presented from the first cycle after reset.
module but_sync #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/but_debounce.sv
// Single-button conditioner: synchronise, debounce, and emit press/release/long-press
// pulses plus a press-toggled LED level. All outputs are registered.
module but_debounce
  import but_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned LONG_CYCLES     = DefLongCycles,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic BUT,
  output logic STATE,
  output logic PRESS,
  output logic RELEASE,
  output logic LONG,
  output logic LED
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DMax = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HMax = HW'(LONG_CYCLES);

  logic          but_s;
  logic          p;
  but_state_e    st;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcnt_inc;
  logic          long_hit;

  but_sync #(
    .RESET_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (BUT),
    .q   (but_s)
  );

  assign p = but_s ^ ACTIVE_LOW;

  // Hold counter saturates at LONG_CYCLES so LONG can only fire once per press.
  always_comb begin
    hcnt_inc = hcnt;
    long_hit = 1'b0;
    if (hcnt != HMax) begin
      hcnt_inc = hcnt + HW'(1);
      long_hit = (hcnt_inc == HMax);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st      <= StReleased;
      dcnt    <= '0;
      hcnt    <= '0;
      STATE   <= 1'b0;
      PRESS   <= 1'b0;
      RELEASE <= 1'b0;
      LONG    <= 1'b0;
      LED     <= 1'b0;
    end else begin
      PRESS   <= 1'b0;
      RELEASE <= 1'b0;
      LONG    <= 1'b0;
      unique case (st)
        StReleased: begin
          if (p) begin
            st   <= StPressWait;
            dcnt <= DW'(1);
          end
        end
        StPressWait: begin
          if (!p) begin
            st <= StReleased;
          end else if (dcnt == DMax) begin
            st    <= StPressed;
            PRESS <= 1'b1;
            STATE <= 1'b1;
            LED   <= ~LED;
            hcnt  <= '0;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        StPressed: begin
          hcnt <= hcnt_inc;
          LONG <= long_hit;
          if (!p) begin
            st   <= StReleaseWait;
            dcnt <= DW'(1);
          end
        end
        StReleaseWait: begin
          // The accepted release wins over a coincident long-press threshold.
          if (!p && dcnt == DMax) begin
            st      <= StReleased;
            RELEASE <= 1'b1;
            STATE   <= 1'b0;
          end else begin
            hcnt <= hcnt_inc;
            LONG <= long_hit;
            if (p) begin
              st <= StPressed;
            end else begin
              dcnt <= dcnt + DW'(1);
            end
          end
        end
        default: st <= StReleased;
      endcase
    end
  end

endmodule

// File: tb/tb_but_debounce.sv
// Directed bench for but_debounce: active-high and active-low instances with
// DEBOUNCE_CYCLES=4, LONG_CYCLES=20; expectations are hand-derived edge numbers.
module tb_but_debounce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic but_a = 1'b0;
  logic but_b = 1'b1;

  logic a_state, a_press, a_release, a_long, a_led;
  logic b_state, b_press, b_release, b_long, b_led;
  logic [4:0] got_a, got_b, exp_v;

  int checks = 0;
  int errors = 0;
  logic led_a = 1'b0;
  logic led_b = 1'b0;

  always #5 clk = ~clk;

  but_debounce #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (20),
    .ACTIVE_LOW      (1'b0)
  ) u_dut_hi (
    .CLK     (clk),
    .RST     (rst),
    .BUT     (but_a),
    .STATE   (a_state),
    .PRESS   (a_press),
    .RELEASE (a_release),
    .LONG    (a_long),
    .LED     (a_led)
  );

  but_debounce #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (20),
    .ACTIVE_LOW      (1'b1)
  ) u_dut_lo (
    .CLK     (clk),
    .RST     (rst),
    .BUT     (but_b),
    .STATE   (b_state),
    .PRESS   (b_press),
    .RELEASE (b_release),
    .LONG    (b_long),
    .LED     (b_led)
  );

  // Vector order: {STATE, PRESS, RELEASE, LONG, LED}
  assign got_a = {a_state, a_press, a_release, a_long, a_led};
  assign got_b = {b_state, b_press, b_release, b_long, b_led};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (got_a !== 5'b0 || got_b !== 5'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %b/%b, expected 00000/00000", i, got_a, got_b);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (got_a !== 5'b0 || got_b !== 5'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %b/%b, expected 00000/00000", i, got_a, got_b);
      end
    end
  endtask

  task automatic test_clean_press();
    for (int i = 0; i < 20; i++) begin
      but_a = (i < 10);
      tick();
      exp_v = {(i >= 6 && i < 16), (i == 6), (i == 16), 1'b0, led_a ^ (i >= 6)};
      checks++;
      if (got_a !== exp_v) begin
        errors++;
        $display("FAIL clean_press cycle %0d: got %b, expected %b", i, got_a, exp_v);
      end
    end
    led_a = ~led_a;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 40; i++) begin
      but_a = (i < 20) ? ((i / 2) % 2 == 0) : (i < 30);
      tick();
      exp_v = {(i >= 26 && i < 36), (i == 26), (i == 36), 1'b0, led_a ^ (i >= 26)};
      checks++;
      if (got_a !== exp_v) begin
        errors++;
        $display("FAIL bounce cycle %0d: got %b, expected %b", i, got_a, exp_v);
      end
    end
    led_a = ~led_a;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_long_press();
    for (int i = 0; i < 50; i++) begin
      but_a = (i < 40);
      tick();
      exp_v = {(i >= 6 && i < 46), (i == 6), (i == 46), (i == 26), led_a ^ (i >= 6)};
      checks++;
      if (got_a !== exp_v) begin
        errors++;
        $display("FAIL long_press cycle %0d: got %b, expected %b", i, got_a, exp_v);
      end
    end
    led_a = ~led_a;
    for (int i = 0; i < 4; i++) tick();
  endtask

  // Glitch is placed so the FSM sits in its release-wait state when LONG is due.
  task automatic test_hold_glitch();
    for (int i = 0; i < 50; i++) begin
      but_a = (i < 23) || (i >= 26 && i < 40);
      tick();
      exp_v = {(i >= 6 && i < 46), (i == 6), (i == 46), (i == 26), led_a ^ (i >= 6)};
      checks++;
      if (got_a !== exp_v) begin
        errors++;
        $display("FAIL hold_glitch cycle %0d: got %b, expected %b", i, got_a, exp_v);
      end
    end
    led_a = ~led_a;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_reset_mid_press();
    for (int i = 0; i < 10; i++) begin
      but_a = 1'b1;
      tick();
      exp_v = {(i >= 6), (i == 6), 1'b0, 1'b0, led_a ^ (i >= 6)};
      checks++;
      if (got_a !== exp_v) begin
        errors++;
        $display("FAIL pre_reset cycle %0d: got %b, expected %b", i, got_a, exp_v);
      end
    end
    rst = 1'b1;
    #2;
    checks++;
    if (got_a !== 5'b0) begin
      errors++;
      $display("FAIL async_reset: got %b, expected 00000", got_a);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (got_a !== 5'b0) begin
        errors++;
        $display("FAIL reset_held cycle %0d: got %b, expected 00000", i, got_a);
      end
    end
    rst = 1'b0;
    led_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_v = {(i >= 6), (i == 6), 1'b0, 1'b0, (i >= 6)};
      checks++;
      if (got_a !== exp_v) begin
        errors++;
        $display("FAIL post_reset_press cycle %0d: got %b, expected %b", i, got_a, exp_v);
      end
    end
    led_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      but_a = 1'b0;
      tick();
      exp_v = {(i < 6), 1'b0, (i == 6), 1'b0, led_a};
      checks++;
      if (got_a !== exp_v) begin
        errors++;
        $display("FAIL post_reset_release cycle %0d: got %b, expected %b", i, got_a, exp_v);
      end
    end
  endtask

  task automatic test_active_low();
    led_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      but_b = (i >= 10);
      tick();
      exp_v = {(i >= 6 && i < 16), (i == 6), (i == 16), 1'b0, led_b ^ (i >= 6)};
      checks++;
      if (got_b !== exp_v) begin
        errors++;
        $display("FAIL active_low cycle %0d: got %b, expected %b", i, got_b, exp_v);
      end
    end
    led_b = ~led_b;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_hold_glitch();
    test_reset_mid_press();
    test_active_low();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
